rx_fsrc: RTL and testbench



---
 rtl/rx_fsrc_pkg.sv | 19 +
 rtl/rx_fsrc_if.sv | 9 +
 rtl/rx_fsrc_drop_gen.sv | 52 +++++
 rtl/rx_fsrc.sv | 129 ++++++++++++
 tb/tb_rx_fsrc.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_fsrc_pkg.sv
// Shared types and sizing helpers for the receive-side fractional sample-rate converter.
package rx_fsrc_pkg;

    localparam int P_DATA_WIDTH  = 512;
    localparam int P_NP          = 16;
    localparam int P_MAX_CONV    = 8;
    localparam int P_ACCUM_WIDTH = 64;

    function automatic int num_samples(input int dw, input int np, input int mc);
        return dw / np / mc;
    endfunction

    localparam int P_NUM_SAMPLES = num_samples(P_DATA_WIDTH, P_NP, P_MAX_CONV);

    typedef logic [P_NP-1:0] sample_t;
    // Beat view: [lane][slot], slot 0 in the least significant bits of each lane.
    typedef sample_t [P_MAX_CONV-1:0][P_NUM_SAMPLES-1:0] lane_slot_t;

endpackage

// File: rtl/rx_fsrc_if.sv
// Beat-wide valid/ready stream used for both the input and output of rx_fsrc.
interface rx_fsrc_if #(parameter int DATA_WIDTH = 512);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rx_fsrc_drop_gen.sv
// Phase accumulator and carry chain: flags which slots of the current beat are placeholders.
module rx_fsrc_drop_gen #(
    parameter int N           = 4,
    parameter int ACCUM_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_fsrc_en,
    input  logic                     i_adv,
    input  logic                     i_set,
    input  logic [ACCUM_WIDTH-1:0]   i_set_val,
    input  logic [ACCUM_WIDTH-1:0]   i_add_val,
    output logic [N-1:0]             o_drop,
    output logic [$clog2(N+1)-1:0]   o_keep
);
    localparam int KW = $clog2(N+1);

    logic [ACCUM_WIDTH-1:0] r_accum;
    logic [ACCUM_WIDTH-1:0] w_accum_end;
    logic [N-1:0]           w_carry;

    always_comb begin
        logic [ACCUM_WIDTH:0] v_sum;
        v_sum       = '0;
        w_accum_end = r_accum;
        w_carry     = '0;
        for (int j = 0; j < N; j++) begin
            v_sum       = {1'b0, w_accum_end} + {1'b0, i_add_val};
            w_carry[j]  = v_sum[ACCUM_WIDTH];
            w_accum_end = v_sum[ACCUM_WIDTH-1:0];
        end
    end

    assign o_drop = i_fsrc_en ? w_carry : '0;

    always_comb begin
        o_keep = KW'(N);
        for (int j = 0; j < N; j++)
            if (o_drop[j]) o_keep = o_keep - KW'(1);
    end

    // A load wins over the advance; the beat taken this cycle already used the old value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_accum <= '0;
        else if (i_set)
            r_accum <= i_set_val;
        else if (i_adv && i_fsrc_en)
            r_accum <= w_accum_end;
    end

endmodule

// File: rtl/rx_fsrc.sv
// Receive FSRC: drops carry-flagged slots and repacks survivors into full output beats.
// Optional RX_FSRC_STATUS_EN builds the saturating dropped-slot counter on drop_count.
module rx_fsrc
    import rx_fsrc_pkg::*;
#(
    parameter int DATA_WIDTH  = P_DATA_WIDTH,
    parameter int NP          = P_NP,
    parameter int MAX_CONV    = P_MAX_CONV,
    parameter int ACCUM_WIDTH = P_ACCUM_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   fsrc_en,
    input  logic [MAX_CONV-1:0]    conv_mask,
    input  logic                   accum_set,
    input  logic [ACCUM_WIDTH-1:0] accum_set_val,
    input  logic [ACCUM_WIDTH-1:0] accum_add_val,
    rx_fsrc_if.slave               s_axis,
    rx_fsrc_if.master              m_axis,
    output logic [31:0]            drop_count
);
    localparam int N   = num_samples(DATA_WIDTH, NP, MAX_CONV);
    localparam int BUF = 2*N - 1;
    localparam int CW  = $clog2(2*N);
    localparam int KW  = $clog2(N+1);

    typedef logic [NP-1:0] smp_t;

    logic [N-1:0]                    w_drop;
    logic [KW-1:0]                   w_keep;
    int                              w_rank [N];
    smp_t [MAX_CONV-1:0][N-1:0]      w_kept;
    smp_t [MAX_CONV-1:0][BUF-1:0]    r_buf, w_buf_next;
    logic [CW-1:0]                   r_cnt, w_cnt_pop, w_cnt_next;
    logic                            w_push, w_pop, w_m_valid;

    rx_fsrc_drop_gen #(.N(N), .ACCUM_WIDTH(ACCUM_WIDTH)) u_drop_gen (
        .clk       (clk),
        .resetn    (resetn),
        .i_fsrc_en (fsrc_en),
        .i_adv     (w_push),
        .i_set     (accum_set),
        .i_set_val (accum_set_val),
        .i_add_val (accum_add_val),
        .o_drop    (w_drop),
        .o_keep    (w_keep)
    );

    // Accepting only while c<N or a pop is guaranteed keeps c_next within 2N-1.
    assign w_m_valid    = r_cnt >= CW'(N);
    assign w_pop        = w_m_valid & m_axis.ready;
    assign s_axis.ready = (r_cnt < CW'(N)) | m_axis.ready;
    assign w_push       = s_axis.valid & s_axis.ready;

    always_comb begin
        int v_r;
        v_r = 0;
        for (int j = 0; j < N; j++) begin
            w_rank[j] = v_r;
            if (!w_drop[j]) v_r++;
        end
    end

    // Kept slots packed to the front, oldest first.
    always_comb begin
        w_kept = '0;
        for (int l = 0; l < MAX_CONV; l++)
            for (int m = 0; m < N; m++)
                for (int j = 0; j < N; j++)
                    if (!w_drop[j] && w_rank[j] == m)
                        w_kept[l][m] = s_axis.data[(l*N+j)*NP +: NP];
    end

    // Pop shifts by N first; the push then appends at the post-pop occupancy.
    always_comb begin
        smp_t [BUF+N-1:0] v_ext;
        w_cnt_pop  = w_pop ? r_cnt - CW'(N) : r_cnt;
        w_cnt_next = w_cnt_pop + (w_push ? CW'(w_keep) : '0);
        w_buf_next = r_buf;
        for (int l = 0; l < MAX_CONV; l++) begin
            v_ext          = '0;
            v_ext[BUF-1:0] = r_buf[l];
            for (int i = 0; i < BUF; i++) begin
                w_buf_next[l][i] = w_pop ? v_ext[i+N] : r_buf[l][i];
                for (int m = 0; m < N; m++)
                    if (w_push && m < int'(w_keep) && int'(w_cnt_pop) + m == i)
                        w_buf_next[l][i] = w_kept[l][m];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_buf <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_buf <= w_buf_next;
        end
    end

    assign m_axis.valid = w_m_valid;

    always_comb begin
        m_axis.data = '0;
        for (int l = 0; l < MAX_CONV; l++)
            for (int m = 0; m < N; m++)
                m_axis.data[(l*N+m)*NP +: NP] = conv_mask[l] ? r_buf[l][m] : '0;
    end

`ifdef RX_FSRC_STATUS_EN
    logic [31:0] r_drop_cnt;
    logic [32:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_cnt} + 33'(N - int'(w_keep));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_drop_cnt <= '0;
        else if (w_push && fsrc_en)
            r_drop_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_rx_fsrc.sv
// Scoreboard bench for rx_fsrc: a queue model of drop/compaction checked at every output handshake.
module tb_rx_fsrc;
    import rx_fsrc_pkg::*;

    localparam int N  = P_NUM_SAMPLES;
    localparam int NC = P_MAX_CONV;
    localparam int NP = P_NP;
    localparam int DW = P_DATA_WIDTH;

    typedef logic [NC-1:0][NP-1:0] col_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fsrc_en;
    logic [NC-1:0] conv_mask;
    logic        accum_set;
    logic [63:0] accum_set_val, accum_add_val;
    logic        s_valid, m_ready;
    lane_slot_t  s_beat;
    logic [31:0] drop_count;

    rx_fsrc_if #(.DATA_WIDTH(DW)) s_if ();
    rx_fsrc_if #(.DATA_WIDTH(DW)) m_if ();

    assign s_if.valid = s_valid;
    assign s_if.data  = s_beat;
    assign m_if.ready = m_ready;

    rx_fsrc dut (
        .clk           (clk),
        .resetn        (resetn),
        .fsrc_en       (fsrc_en),
        .conv_mask     (conv_mask),
        .accum_set     (accum_set),
        .accum_set_val (accum_set_val),
        .accum_add_val (accum_add_val),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0, n_out = 0;
    col_t        sq[$];
    lane_slot_t  exp_q[$];
    logic [63:0] m_acc = '0;
    logic [63:0] m_dc  = '0;
    lane_slot_t  last_out;

    function automatic lane_slot_t rnd_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return lane_slot_t'(v);
    endfunction

    function automatic int occ();
        return sq.size() + N*exp_q.size();
    endfunction

    function automatic lane_slot_t masked(input lane_slot_t b);
        lane_slot_t r;
        r = b;
        for (int l = 0; l < NC; l++) if (!conv_mask[l]) r[l] = '0;
        return r;
    endfunction

    function automatic logic [31:0] exp_dc();
`ifdef RX_FSRC_STATUS_EN
        return (m_dc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_dc[31:0];
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] dc_if_en(input logic [31:0] v);
`ifdef RX_FSRC_STATUS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic model_clear();
        sq.delete();
        exp_q.delete();
        m_acc = '0;
        m_dc  = '0;
    endtask

    // One clock: compare at the falling edge, update the model, then step past the rising edge.
    task automatic tick(output bit acc_o);
        logic [N-1:0] drop;
        logic [64:0]  s;
        logic [63:0]  a;
        bit           sr;
        lane_slot_t   e, b;
        col_t         col;
        @(negedge clk);
        sr = (occ() < N) || m_ready;
        n_chk++;
        if (m_if.valid !== (exp_q.size() > 0)) begin
            n_fail++;
            $display("FAIL m_valid: got %b want %b", m_if.valid, exp_q.size() > 0);
        end
        n_chk++;
        if (s_if.ready !== sr) begin
            n_fail++;
            $display("FAIL s_ready: got %b want %b", s_if.ready, sr);
        end
        n_chk++;
        if (drop_count !== exp_dc()) begin
            n_fail++;
            $display("FAIL drop_count: got %0d want %0d", drop_count, exp_dc());
        end
        if (exp_q.size() > 0 && m_ready) begin
            last_out = lane_slot_t'(m_if.data);
            n_out++;
            e = masked(exp_q.pop_front());
            n_chk++;
            if (m_if.data !== e) begin
                n_fail++;
                $display("FAIL out_beat: got %h want %h", m_if.data, e);
            end
        end
        acc_o = s_valid && sr;
        a = m_acc;
        drop = '0;
        for (int j = 0; j < N; j++) begin
            s = {1'b0, a} + {1'b0, accum_add_val};
            drop[j] = s[64];
            a = s[63:0];
        end
        if (!fsrc_en) drop = '0;
        if (acc_o) begin
            for (int j = 0; j < N; j++)
                if (!drop[j]) begin
                    for (int l = 0; l < NC; l++) col[l] = s_beat[l][j];
                    sq.push_back(col);
                end
            m_dc = m_dc + 64'($countones(drop));
            while (sq.size() >= N) begin
                for (int m = 0; m < N; m++) begin
                    col = sq.pop_front();
                    for (int l = 0; l < NC; l++) b[l][m] = col[l];
                end
                exp_q.push_back(b);
            end
        end
        if (accum_set) m_acc = accum_set_val;
        else if (acc_o && fsrc_en) m_acc = a;
        n_chk++;
        if (occ() > 2*N-1) begin
            n_fail++;
            $display("FAIL occupancy: got %0d want <= %0d", occ(), 2*N-1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; fsrc_en = 1'b0; conv_mask = '1; accum_set = 1'b0;
        accum_set_val = '0; accum_add_val = '0; s_valid = 1'b0; m_ready = 1'b0; s_beat = '0;
        model_clear();
        #12;
        n_chk++;
        if (m_if.valid !== 1'b0 || m_if.data !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got valid=%b data=%h want 0", m_if.valid, m_if.data);
        end
        n_chk++;
        if (drop_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_drop_count: got %0d want 0", drop_count);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        n_chk++;
        if (s_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %b want 1", s_if.ready);
        end
    endtask

    task automatic test_passthrough();
        bit ac;
        int n0;
        n0 = n_out;
        fsrc_en = 1'b0; m_ready = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_beat = rnd_beat();
            tick(ac);
            n_chk++;
            if (m_if.valid !== 1'b1) begin
                n_fail++;
                $display("FAIL pass_latency: beat %0d got valid=%b want 1", i, m_if.valid);
            end
        end
        s_valid = 1'b0;
        tick(ac);
        n_chk++;
        if (n_out - n0 !== 6) begin
            n_fail++;
            $display("FAIL pass_count: got %0d want 6", n_out - n0);
        end
    endtask

    task automatic test_half_rate();
        bit ac;
        lane_slot_t A, B, hx;
        A = rnd_beat(); B = rnd_beat();
        accum_set = 1'b1; accum_set_val = '0; s_valid = 1'b0;
        tick(ac);
        accum_set = 1'b0; fsrc_en = 1'b1; accum_add_val = 64'h8000_0000_0000_0000; m_ready = 1'b1;
        s_valid = 1'b1; s_beat = A; tick(ac);
        s_beat = B; tick(ac);
        s_valid = 1'b0; tick(ac);
        for (int l = 0; l < NC; l++) hx[l] = {B[l][2], B[l][0], A[l][2], A[l][0]};
        n_chk++;
        if (last_out !== hx) begin
            n_fail++;
            $display("FAIL half_rate: got %h want %h", last_out, hx);
        end
        n_chk++;
        if (drop_count !== dc_if_en(32'd4)) begin
            n_fail++;
            $display("FAIL half_rate_drops: got %0d want %0d", drop_count, dc_if_en(32'd4));
        end
    endtask

    task automatic test_accum_set();
        bit ac;
        lane_slot_t P, C, D, x;
        P = rnd_beat(); C = rnd_beat(); D = rnd_beat();
        accum_add_val = 64'd1; fsrc_en = 1'b1; m_ready = 1'b1;
        accum_set = 1'b1; accum_set_val = '1; s_valid = 1'b0;
        tick(ac);
        accum_set = 1'b0; s_valid = 1'b1; s_beat = P; tick(ac);
        accum_set = 1'b1; s_beat = C; tick(ac);
        accum_set = 1'b0; s_beat = D; tick(ac);
        for (int l = 0; l < NC; l++) x[l] = {C[l][0], P[l][3], P[l][2], P[l][1]};
        n_chk++;
        if (last_out !== x) begin
            n_fail++;
            $display("FAIL accum_set_load: got %h want %h", last_out, x);
        end
        s_valid = 1'b0; tick(ac);
        for (int l = 0; l < NC; l++) x[l] = {D[l][1], C[l][3], C[l][2], C[l][1]};
        n_chk++;
        if (last_out !== x) begin
            n_fail++;
            $display("FAIL accum_set_concurrent: got %h want %h", last_out, x);
        end
        n_chk++;
        if (drop_count !== dc_if_en(32'd6)) begin
            n_fail++;
            $display("FAIL accum_set_drops: got %0d want %0d", drop_count, dc_if_en(32'd6));
        end
    endtask

    task automatic test_backpressure();
        bit ac, have_held, saw_stall;
        logic [DW-1:0] held;
        int guard;
        have_held = 1'b0; saw_stall = 1'b0; held = '0;
        fsrc_en = 1'b1; accum_add_val = 64'h4000_0000_0000_0000;
        m_ready = 1'b0; s_valid = 1'b1; s_beat = rnd_beat();
        for (int i = 0; i < 10; i++) begin
            tick(ac);
            if (ac) s_beat = rnd_beat();
            if (s_if.ready === 1'b0) saw_stall = 1'b1;
            if (m_if.valid === 1'b1) begin
                if (have_held) begin
                    n_chk++;
                    if (m_if.data !== held) begin
                        n_fail++;
                        $display("FAIL bp_stable: got %h want %h", m_if.data, held);
                    end
                end
                held = m_if.data; have_held = 1'b1;
            end
        end
        n_chk++;
        if (saw_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_s_ready_drop: got %b want 1", saw_stall);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(ac);
            if (ac) s_beat = rnd_beat();
        end
        s_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick(ac);
            guard++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pending beats want 0", exp_q.size());
        end
    endtask

    task automatic test_conv_mask();
        bit ac;
        int n0;
        n0 = n_out;
        conv_mask = 8'h01; fsrc_en = 1'b0; m_ready = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_beat = rnd_beat();
            tick(ac);
            if (n_out != n0) begin
                n_chk++;
                if (last_out[NC-1:1] !== '0) begin
                    n_fail++;
                    $display("FAIL conv_mask_zero: got %h want 0", last_out[NC-1:1]);
                end
            end
        end
        s_valid = 1'b0;
        tick(ac);
        conv_mask = '1;
    endtask

    task automatic test_reset_mid();
        bit ac;
        lane_slot_t E;
        resetn = 1'b0; model_clear();
        @(posedge clk); #1;
        resetn = 1'b1;
        fsrc_en = 1'b1; m_ready = 1'b0; s_valid = 1'b1;
        accum_add_val = 64'h4000_0000_0000_0000; s_beat = rnd_beat(); tick(ac);
        accum_add_val = 64'h8000_0000_0000_0000; s_beat = rnd_beat(); tick(ac);
        s_valid = 1'b0;
        n_chk++;
        if (occ() !== 5 || m_if.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fill: got occ=%0d valid=%b want occ=5 valid=1", occ(), m_if.valid);
        end
        resetn = 1'b0;
        #2;
        n_chk++;
        if (m_if.valid !== 1'b0 || m_if.data !== '0 || drop_count !== 32'd0 || s_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b dc=%0d ready=%b want 0/0/1", m_if.valid, drop_count, s_if.ready);
        end
        model_clear();
        @(posedge clk); #1;
        resetn = 1'b1;
        E = rnd_beat();
        fsrc_en = 1'b0; m_ready = 1'b1; s_valid = 1'b1; s_beat = E;
        tick(ac);
        s_valid = 1'b0;
        tick(ac);
        n_chk++;
        if (last_out !== E) begin
            n_fail++;
            $display("FAIL post_reset_first: got %h want %h", last_out, E);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_half_rate();
        test_accum_set();
        test_backpressure();
        test_conv_mask();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
